cache_control: RTL and testbench

Sequencing FSM for the 2-way, 8-set, 16-byte-line write-back cache datapath. It decodes CPU requests against the per-way hit and dirty flags and drives every datapath load/select strobe. It runs the physical-memory handshake for write-back and allocate, and maintains the per-set LRU bit. It sits beside `cache_datapath` inside the `cache` top level, between the CPU memory port and physical memory.

---
 rtl/lc3b_types.sv | 7 +
 rtl/cache_control.sv | 73 +++++++
 tb/tb_cache_control.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared cache controller state encoding and physical-address select codes.
package lc3b_types;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} cache_state_t;
  localparam logic [1:0] PMEM_SEL_W1  = 2'b00;
  localparam logic [1:0] PMEM_SEL_W2  = 2'b01;
  localparam logic [1:0] PMEM_SEL_CPU = 2'b10;
endpackage

// File: rtl/cache_control.sv
// cache_control: 2-way write-back cache sequencer; decodes hits, drives array strobes and the pmem handshake.
module cache_control
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  input  logic       ishit_w1,
  input  logic       ishit_w2,
  input  logic       isdirty_w1,
  input  logic       isdirty_w2,
  input  logic       lru_out,
  output logic       load_lru,
  output logic       lru_in,
  output logic       load_dirty_w1,
  output logic       load_valid_w1,
  output logic       load_tag_w1,
  output logic       load_datastore_w1,
  output logic       load_dirty_w2,
  output logic       load_valid_w2,
  output logic       load_tag_w2,
  output logic       load_datastore_w2,
  output logic       dirty_array_w1_in,
  output logic       dirty_array_w2_in,
  output logic       datastore_in_mux_sel,
  output logic [1:0] pmem_address_mux_sel
);
  cache_state_t r_state, w_next;
  logic w_req, w_hit, w_victim_dirty, w_hit_cyc, w_wr_hit, w_fill;
  assign w_req          = mem_read | mem_write;
  assign w_hit          = ishit_w1 | ishit_w2;
  assign w_victim_dirty = lru_out ? isdirty_w2 : isdirty_w1;
  assign w_hit_cyc      = (r_state == IDLE) && w_req && w_hit;
  assign w_wr_hit       = w_hit_cyc && mem_write;
  assign w_fill         = (r_state == ALLOCATE) && pmem_resp;
  always_ff @(posedge clk) begin
    r_state <= reset ? IDLE : w_next;
  end
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:      w_next = (w_req && !w_hit) ? (w_victim_dirty ? WRITEBACK : ALLOCATE) : IDLE;
      WRITEBACK: w_next = pmem_resp ? ALLOCATE : WRITEBACK;
      ALLOCATE:  w_next = pmem_resp ? IDLE : ALLOCATE;
      default:   w_next = IDLE;
    endcase
  end
  // way 2 wins a double hit, matching the datapath read mux
  always_comb begin
    mem_resp             = w_hit_cyc;
    load_lru             = w_hit_cyc;
    lru_in               = w_hit_cyc && !ishit_w2;
    pmem_write           = r_state == WRITEBACK;
    pmem_read            = r_state == ALLOCATE;
    datastore_in_mux_sel = w_wr_hit;
    dirty_array_w1_in    = w_wr_hit && !ishit_w2;
    dirty_array_w2_in    = w_wr_hit && ishit_w2;
    load_datastore_w1    = (w_wr_hit && !ishit_w2) || (w_fill && !lru_out);
    load_datastore_w2    = (w_wr_hit && ishit_w2) || (w_fill && lru_out);
    load_dirty_w1        = load_datastore_w1;
    load_dirty_w2        = load_datastore_w2;
    load_tag_w1          = w_fill && !lru_out;
    load_tag_w2          = w_fill && lru_out;
    load_valid_w1        = load_tag_w1;
    load_valid_w2        = load_tag_w2;
    pmem_address_mux_sel = (r_state == WRITEBACK) ? (lru_out ? PMEM_SEL_W2 : PMEM_SEL_W1) : PMEM_SEL_CPU;
  end
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: random cache traffic against a set/way/LRU model of the arrays; every output checked each cycle.
module tb_cache_control;
  typedef struct packed {
    logic mem_resp, pmem_read, pmem_write, load_lru, lru_in;
    logic [1:0] ld_dirty, ld_valid, ld_tag, ld_ds, dirty_in;
    logic ds_sel;
    logic [1:0] sel;
  } ov_t;
  logic clk = 0, reset, mem_read, mem_write, pmem_resp;
  logic ishit_w1, ishit_w2, isdirty_w1, isdirty_w2, lru_out;
  logic mem_resp, pmem_read, pmem_write, load_lru, lru_in;
  logic load_dirty_w1, load_valid_w1, load_tag_w1, load_datastore_w1;
  logic load_dirty_w2, load_valid_w2, load_tag_w2, load_datastore_w2;
  logic dirty_array_w1_in, dirty_array_w2_in, datastore_in_mux_sel;
  logic [1:0] pmem_address_mux_sel;
  ov_t act;
  logic [3:0] m_tag [8][2];
  bit m_v [8][2];
  bit m_d [8][2];
  bit m_lru [8];
  int n_chk = 0, n_pass = 0;
  cache_control dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .ishit_w1(ishit_w1), .ishit_w2(ishit_w2), .isdirty_w1(isdirty_w1), .isdirty_w2(isdirty_w2),
    .lru_out(lru_out), .load_lru(load_lru), .lru_in(lru_in),
    .load_dirty_w1(load_dirty_w1), .load_valid_w1(load_valid_w1), .load_tag_w1(load_tag_w1),
    .load_datastore_w1(load_datastore_w1), .load_dirty_w2(load_dirty_w2), .load_valid_w2(load_valid_w2),
    .load_tag_w2(load_tag_w2), .load_datastore_w2(load_datastore_w2),
    .dirty_array_w1_in(dirty_array_w1_in), .dirty_array_w2_in(dirty_array_w2_in),
    .datastore_in_mux_sel(datastore_in_mux_sel), .pmem_address_mux_sel(pmem_address_mux_sel)
  );
  always #5 clk = ~clk;
  assign act = {mem_resp, pmem_read, pmem_write, load_lru, lru_in,
                load_dirty_w2, load_dirty_w1, load_valid_w2, load_valid_w1,
                load_tag_w2, load_tag_w1, load_datastore_w2, load_datastore_w1,
                dirty_array_w2_in, dirty_array_w1_in, datastore_in_mux_sel, pmem_address_mux_sel};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic ov_t idle0();
    ov_t o = '0;
    o.sel = 2'b10;
    return o;
  endfunction
  // inputs are driven at the falling edge; outputs sampled 1ns later, well clear of the rising edge
  task automatic cyc(input string tag, input ov_t e);
    #1 chk(tag, act, e);
    @(negedge clk);
  endtask
  task automatic set_flags(input int s, input logic [3:0] t);
    ishit_w1   = m_v[s][0] && m_tag[s][0] == t;
    ishit_w2   = m_v[s][1] && m_tag[s][1] == t;
    isdirty_w1 = m_v[s][0] && m_d[s][0];
    isdirty_w2 = m_v[s][1] && m_d[s][1];
    lru_out    = m_lru[s];
  endtask
  task automatic txn(input int s, input logic [3:0] t, input bit rd, input bit wr, input bit drop, input bit rst);
    ov_t e;
    int w, v, kw, ka;
    mem_read = rd; mem_write = wr; pmem_resp = 0;
    for (int p = 0; p < 2; p++) begin
      set_flags(s, t);
      if (ishit_w1 || ishit_w2) begin
        w = ishit_w2 ? 1 : 0;
        e = idle0();
        e.mem_resp = 1; e.load_lru = 1; e.lru_in = (w == 0);
        if (wr) begin
          e.ld_ds[w] = 1; e.ld_dirty[w] = 1; e.dirty_in[w] = 1; e.ds_sel = 1;
        end
        cyc(wr ? "write_hit" : "read_hit", e);
        m_lru[s] = (w == 0);
        if (wr) m_d[s][w] = 1;
        mem_read = 0; mem_write = 0;
        return;
      end
      if (p == 1) begin
        chk("refill_hit", 0, 1);
        return;
      end
      cyc("miss", idle0());
      v = m_lru[s];
      if (m_v[s][v] && m_d[s][v]) begin
        kw = $urandom_range(1, 5);
        for (int i = 0; i < kw; i++) begin
          pmem_resp = (i == kw - 1);
          e = '0; e.pmem_write = 1; e.sel = {1'b0, v[0]};
          cyc("writeback", e);
        end
        pmem_resp = 0;
      end
      ka = rst ? $urandom_range(4, 6) : drop ? $urandom_range(3, 5) : $urandom_range(1, 5);
      for (int i = 0; i < ka; i++) begin
        e = idle0(); e.pmem_read = 1;
        if (rst && i == 2) begin
          reset = 1;
          cyc("alloc_rst", e);
          reset = 0; mem_read = 0; mem_write = 0;
          cyc("rst_idle", idle0());
          return;
        end
        if (drop && i == 1) begin
          mem_read = 0; mem_write = 0;
        end
        pmem_resp = (i == ka - 1);
        if (pmem_resp) begin
          e.ld_ds[v] = 1; e.ld_tag[v] = 1; e.ld_valid[v] = 1; e.ld_dirty[v] = 1;
        end
        cyc("allocate", e);
      end
      pmem_resp = 0;
      m_tag[s][v] = t; m_v[s][v] = 1; m_d[s][v] = 0;
      if (!(mem_read || mem_write)) begin
        set_flags(s, t);
        cyc("drop_idle", idle0());
        return;
      end
    end
  endtask
  initial begin
    ov_t e;
    bit rd, wr;
    reset = 1; mem_read = 0; mem_write = 0; pmem_resp = 0;
    ishit_w1 = 0; ishit_w2 = 0; isdirty_w1 = 0; isdirty_w2 = 0; lru_out = 0;
    for (int s = 0; s < 8; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_v[s][w] = 0; m_d[s][w] = 0; m_tag[s][w] = '0;
      end
    end
    @(negedge clk);
    cyc("reset", idle0());
    reset = 0;
    cyc("idle", idle0());
    pmem_resp = 1;
    cyc("stray_pmem_resp", idle0());
    pmem_resp = 0;
    cyc("still_idle", idle0());
    txn(3, 5, 1, 0, 0, 0);
    txn(3, 6, 1, 0, 0, 0);
    txn(3, 6, 0, 1, 0, 0);
    txn(3, 7, 1, 0, 0, 0);
    txn(3, 8, 1, 0, 0, 0);
    txn(3, 8, 1, 1, 0, 0);
    txn(5, 1, 1, 0, 0, 1);
    txn(5, 1, 1, 0, 1, 0);
    txn(5, 1, 1, 0, 0, 0);
    mem_read = 1; mem_write = 1; ishit_w1 = 1; ishit_w2 = 1; isdirty_w1 = 0; isdirty_w2 = 0; lru_out = 0;
    e = idle0();
    e.mem_resp = 1; e.load_lru = 1; e.ld_ds[1] = 1; e.ld_dirty[1] = 1; e.dirty_in[1] = 1; e.ds_sel = 1;
    cyc("double_hit", e);
    mem_read = 0; mem_write = 0; ishit_w1 = 0; ishit_w2 = 0;
    cyc("idle_after", idle0());
    for (int n = 0; n < 300; n++) begin
      rd = $urandom_range(0, 1);
      wr = rd ? bit'($urandom_range(0, 1)) : 1'b1;
      txn($urandom_range(0, 7), 4'($urandom_range(0, 3)), rd, wr,
          $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
